// File: rtl/elevator_request_scheduler_pkg.sv
// Shared types and helpers for the elevator request scheduler.
//   dir_t        : sweep direction reported to the car controller
//   MAX_FLOORS   : widest building the scheduler supports
//   floor_sel_t  : result of a floor search (found flag + floor index)
//   highest_set  : highest set bit strictly below a bound
//   lowest_set   : lowest set bit strictly above a bound
package elevator_pkg;

   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DOWN = 2'b10
   } dir_t;

   localparam int MAX_FLOORS = 16;

   typedef struct packed {
      logic                          found;
      logic [$clog2(MAX_FLOORS)-1:0] floor;
   } floor_sel_t;

   // Highest index i with vec[i] set and i < bound. A bound of MAX_FLOORS
   // searches the whole vector.
   function automatic floor_sel_t highest_set(input logic [MAX_FLOORS-1:0] vec,
                                              input int bound);
      floor_sel_t r;
      r = '0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (i < bound && vec[i]) begin
            r.found = 1'b1;
            r.floor = 4'(i);
         end
      end
      return r;
   endfunction

   // Lowest index i with vec[i] set and i > bound. A bound of -1 searches
   // the whole vector.
   function automatic floor_sel_t lowest_set(input logic [MAX_FLOORS-1:0] vec,
                                             input int bound);
      floor_sel_t r;
      r = '0;
      for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
         if (i > bound && vec[i]) begin
            r.found = 1'b1;
            r.floor = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Request/target bundle between the button debounce logic, the scheduler
// and the car motion controller.
//   req_cab/req_up/req_down : level button inputs, one bit per floor
//   curr_floor, arrived     : car position and door-open pulse
//   pending                 : latched requests per floor (floor LEDs)
//   target_floor/valid, dir : registered scheduling decision
// master = request/car side, slave = scheduler.
interface elevator_request_scheduler_if #(
   parameter int NUM_FLOORS = 6
);
   import elevator_pkg::*;

   localparam int FLOOR_W = $clog2(NUM_FLOORS);

   logic [NUM_FLOORS-1:0] req_cab;
   logic [NUM_FLOORS-1:0] req_up;
   logic [NUM_FLOORS-1:0] req_down;
   logic [FLOOR_W-1:0]    curr_floor;
   logic                  arrived;
   logic [NUM_FLOORS-1:0] pending;
   logic [FLOOR_W-1:0]    target_floor;
   logic                  target_valid;
   dir_t                  dir;

   modport master (
      output req_cab, req_up, req_down, curr_floor, arrived,
      input  pending, target_floor, target_valid, dir
   );

   modport slave (
      input  req_cab, req_up, req_down, curr_floor, arrived,
      output pending, target_floor, target_valid, dir
   );

endinterface

// File: rtl/elevator_request_scheduler_latch.sv
// One bank of per-floor request latches (cab, hall-up or hall-down).
//   clk, reset  : clock, asynchronous active-low reset
//   req         : level request per floor
//   arrived     : door-open pulse at curr_floor
//   curr_floor  : floor of the car
//   clr_en      : this bank may be cleared by the current arrival
//   latch       : latched request per floor
// MASK marks floors whose button cannot exist (top-floor up, ground-floor
// down); those bits are held at zero.
module elevator_request_latch #(
   parameter int                    NUM_FLOORS = 6,
   parameter int                    FLOOR_W    = $clog2(NUM_FLOORS),
   parameter logic [NUM_FLOORS-1:0] MASK       = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] req,
   input  logic                  arrived,
   input  logic [FLOOR_W-1:0]    curr_floor,
   input  logic                  clr_en,
   output logic [NUM_FLOORS-1:0] latch
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latch <= '0;
      end else begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            // Clear is tested before set so a button held during the
            // arrival at that floor does not re-latch. An out-of-range
            // curr_floor never matches any i, so it clears nothing.
            if (MASK[i])
               latch[i] <= 1'b0;
            else if (clr_en && arrived && (int'(curr_floor) == i))
               latch[i] <= 1'b0;
            else if (req[i])
               latch[i] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN elevator request scheduler.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : slave side of elevator_request_scheduler_if
//                (requests, car position in; pending, target, dir out)
// Latches cab/up/down requests, runs the UP/DOWN/IDLE sweep state and
// registers the next floor to serve. All outputs come from registers.
module elevator_request_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 6
) (
   input logic                          clk,
   input logic                          reset,
   elevator_request_scheduler_if.slave  bus
);

   localparam int FLOOR_W = $clog2(NUM_FLOORS);
   localparam logic [NUM_FLOORS-1:0] UP_MASK   = NUM_FLOORS'(1) << (NUM_FLOORS - 1);
   localparam logic [NUM_FLOORS-1:0] DOWN_MASK = NUM_FLOORS'(1);

   logic [NUM_FLOORS-1:0] cab_latch, up_latch, down_latch, any_latch;
   logic [MAX_FLOORS-1:0] any_ext, up_sel_ext, down_sel_ext;
   logic                  above, below, any_set;
   dir_t                  dir_q, dir_next;
   floor_sel_t            sel;
   logic [FLOOR_W-1:0]    target_floor_q;
   logic                  target_valid_q;

   // Hall latches clear only when the car is leaving in their direction.
   elevator_request_latch #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W), .MASK('0)) u_cab (
      .clk(clk), .reset(reset), .req(bus.req_cab), .arrived(bus.arrived),
      .curr_floor(bus.curr_floor), .clr_en(1'b1), .latch(cab_latch)
   );

   elevator_request_latch #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W), .MASK(UP_MASK)) u_up (
      .clk(clk), .reset(reset), .req(bus.req_up), .arrived(bus.arrived),
      .curr_floor(bus.curr_floor), .clr_en(dir_q != DIR_DOWN), .latch(up_latch)
   );

   elevator_request_latch #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W), .MASK(DOWN_MASK)) u_down (
      .clk(clk), .reset(reset), .req(bus.req_down), .arrived(bus.arrived),
      .curr_floor(bus.curr_floor), .clr_en(dir_q != DIR_UP), .latch(down_latch)
   );

   assign any_latch    = cab_latch | up_latch | down_latch;
   assign any_set      = |any_latch;
   assign any_ext      = MAX_FLOORS'(any_latch);
   assign up_sel_ext   = MAX_FLOORS'(cab_latch | up_latch);
   assign down_sel_ext = MAX_FLOORS'(cab_latch | down_latch);

   // A request at curr_floor itself counts as neither above nor below.
   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (any_latch[i] && i > int'(bus.curr_floor)) above = 1'b1;
         if (any_latch[i] && i < int'(bus.curr_floor)) below = 1'b1;
      end
   end

   always_comb begin
      dir_next = dir_q;
      unique case (dir_q)
         DIR_IDLE: begin
            if (above)      dir_next = DIR_UP;
            else if (below) dir_next = DIR_DOWN;
         end
         DIR_UP: begin
            if (above)      dir_next = DIR_UP;
            else if (below) dir_next = DIR_DOWN;
            else            dir_next = DIR_IDLE;
         end
         DIR_DOWN: begin
            if (below)      dir_next = DIR_DOWN;
            else if (above) dir_next = DIR_UP;
            else            dir_next = DIR_IDLE;
         end
         default: dir_next = DIR_IDLE;
      endcase
   end

   // Serve requests ahead in the sweep first; when only opposite-direction
   // hall calls remain ahead, go to the far end of the pending set.
   always_comb begin
      sel = '0;
      unique case (dir_next)
         DIR_UP: begin
            sel = lowest_set(up_sel_ext, int'(bus.curr_floor));
            if (!sel.found) sel = highest_set(any_ext, MAX_FLOORS);
         end
         DIR_DOWN: begin
            sel = highest_set(down_sel_ext, int'(bus.curr_floor));
            if (!sel.found) sel = lowest_set(any_ext, -1);
         end
         default: begin
            sel.found = any_ext[bus.curr_floor];
            sel.floor = 4'(bus.curr_floor);
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir_q          <= DIR_IDLE;
         target_floor_q <= '0;
         target_valid_q <= 1'b0;
      end else begin
         dir_q          <= dir_next;
         target_valid_q <= any_set;
         if (any_set && sel.found)
            target_floor_q <= FLOOR_W'(sel.floor);
      end
   end

   assign bus.pending      = any_latch;
   assign bus.dir          = dir_q;
   assign bus.target_floor = target_floor_q;
   assign bus.target_valid = target_valid_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler (NUM_FLOORS=6).
// Stimulus is applied on the falling edge; each stimulus step pushes its
// expected outputs with the number of rising edges after which they are due.
// A monitor samples 1 time unit after each rising edge and compares entries
// that have come due.
module tb_elevator_request_scheduler;
   import elevator_pkg::*;

   localparam int NF = 6;
   localparam int K_PEND = 0;
   localparam int K_DIR  = 1;
   localparam int K_TF   = 2;
   localparam int K_TV   = 3;

   typedef struct {
      string tag;
      int    kind;
      int    val;
      int    due;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;
   exp_t sb[$];

   elevator_request_scheduler_if #(.NUM_FLOORS(NF)) bus ();

   elevator_request_scheduler #(.NUM_FLOORS(NF)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
   endtask

   task automatic expect_out(input string tag, input int kind, input int val, input int k);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.val  = val;
      e.due  = cyc + k;
      sb.push_back(e);
   endtask

   task automatic check_due();
      int act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            unique case (sb[i].kind)
               K_PEND:  act = int'(bus.pending);
               K_DIR:   act = int'(bus.dir);
               K_TF:    act = int'(bus.target_floor);
               default: act = int'(bus.target_valid);
            endcase
            if (sb[i].due < cyc) check_eq({sb[i].tag, "_late"}, cyc, sb[i].due);
            else check_eq(sb[i].tag, act, sb[i].val);
            sb.delete(i);
         end
      end
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      check_due();
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.req_cab  = '0;
      bus.req_up   = '0;
      bus.req_down = '0;
      bus.arrived  = 1'b0;
   endtask

   initial begin
      clear_inputs();
      bus.curr_floor = '0;

      // Reset state
      wait_neg(2);
      check_eq("rst_pending", int'(bus.pending), 0);
      check_eq("rst_dir", int'(bus.dir), int'(DIR_IDLE));
      check_eq("rst_tvalid", int'(bus.target_valid), 0);
      check_eq("rst_tfloor", int'(bus.target_floor), 0);
      reset = 1'b1;

      // Simple up: cab request at floor 4 from floor 0
      wait_neg(1);
      bus.curr_floor = 3'd0;
      bus.req_cab = 6'b010000;
      expect_out("up_pending", K_PEND, 'b010000, 1);
      expect_out("up_dir", K_DIR, int'(DIR_UP), 2);
      expect_out("up_tfloor", K_TF, 4, 2);
      expect_out("up_tvalid", K_TV, 1, 2);
      wait_neg(1);
      bus.req_cab = '0;
      wait_neg(2);
      bus.curr_floor = 3'd4;
      bus.arrived = 1'b1;
      expect_out("up_arr_pending", K_PEND, 0, 1);
      expect_out("up_arr_dir", K_DIR, int'(DIR_IDLE), 2);
      expect_out("up_arr_tvalid", K_TV, 0, 2);
      expect_out("up_arr_tfloor_hold", K_TF, 4, 2);
      wait_neg(1);
      bus.arrived = 1'b0;
      wait_neg(2);

      // SCAN ordering from floor 2
      bus.curr_floor = 3'd2;
      bus.req_cab  = 6'b100000;
      bus.req_up   = 6'b001000;
      bus.req_down = 6'b000010;
      expect_out("scan_pending", K_PEND, 'b101010, 1);
      expect_out("scan_dir", K_DIR, int'(DIR_UP), 2);
      expect_out("scan_tfloor3", K_TF, 3, 2);
      expect_out("scan_tvalid", K_TV, 1, 2);
      wait_neg(1);
      clear_inputs();
      wait_neg(2);
      bus.curr_floor = 3'd3;
      bus.arrived = 1'b1;
      expect_out("scan_at3_pending", K_PEND, 'b100010, 1);
      expect_out("scan_at3_tfloor5", K_TF, 5, 2);
      expect_out("scan_at3_dir", K_DIR, int'(DIR_UP), 2);
      wait_neg(1);
      bus.arrived = 1'b0;
      wait_neg(2);
      bus.curr_floor = 3'd5;
      bus.arrived = 1'b1;
      expect_out("scan_at5_pending", K_PEND, 'b000010, 1);
      expect_out("scan_at5_dir", K_DIR, int'(DIR_DOWN), 2);
      expect_out("scan_at5_tfloor1", K_TF, 1, 2);
      wait_neg(1);
      bus.arrived = 1'b0;
      wait_neg(2);
      bus.curr_floor = 3'd1;
      bus.arrived = 1'b1;
      expect_out("scan_at1_pending", K_PEND, 0, 1);
      expect_out("scan_at1_dir", K_DIR, int'(DIR_IDLE), 2);
      expect_out("scan_at1_tvalid", K_TV, 0, 2);
      wait_neg(1);
      bus.arrived = 1'b0;
      wait_neg(2);

      // Direction-aware clear at floor 3 while sweeping up
      bus.curr_floor = 3'd3;
      bus.req_cab  = 6'b100000;
      bus.req_up   = 6'b001000;
      bus.req_down = 6'b001000;
      expect_out("dac_pending", K_PEND, 'b101000, 1);
      expect_out("dac_dir", K_DIR, int'(DIR_UP), 2);
      wait_neg(1);
      clear_inputs();
      wait_neg(2);
      bus.arrived = 1'b1;
      expect_out("dac_keep_down3", K_PEND, 'b101000, 1);
      expect_out("dac_tfloor5", K_TF, 5, 2);
      wait_neg(1);
      bus.arrived = 1'b0;
      wait_neg(2);
      bus.curr_floor = 3'd5;
      bus.arrived = 1'b1;
      expect_out("dac_at5_pending", K_PEND, 'b001000, 1);
      expect_out("dac_at5_dir", K_DIR, int'(DIR_DOWN), 2);
      expect_out("dac_at5_tfloor3", K_TF, 3, 2);
      wait_neg(1);
      bus.arrived = 1'b0;
      wait_neg(2);
      // Sweeping down now: down[3] clears; up[3] must already be gone.
      bus.curr_floor = 3'd3;
      bus.arrived = 1'b1;
      expect_out("dac_up3_was_cleared", K_PEND, 0, 1);
      expect_out("dac_end_dir", K_DIR, int'(DIR_IDLE), 2);
      wait_neg(1);
      bus.arrived = 1'b0;
      wait_neg(2);

      // Masked hall buttons
      bus.curr_floor = 3'd0;
      bus.req_up   = 6'b100000;
      bus.req_down = 6'b000001;
      expect_out("mask_pending", K_PEND, 0, 1);
      expect_out("mask_tvalid", K_TV, 0, 2);
      expect_out("mask_dir", K_DIR, int'(DIR_IDLE), 2);
      wait_neg(1);
      clear_inputs();
      wait_neg(2);

      // Clear beats set: cab button pressed during arrival at that floor
      bus.curr_floor = 3'd2;
      bus.req_cab = 6'b000100;
      bus.arrived = 1'b1;
      expect_out("clr_beats_set", K_PEND, 0, 1);
      expect_out("clr_beats_set_tv", K_TV, 0, 2);
      wait_neg(1);
      clear_inputs();
      wait_neg(2);

      // Out-of-range arrival leaves latches untouched
      bus.curr_floor = 3'd0;
      bus.req_cab  = 6'b000010;
      bus.req_down = 6'b010000;
      expect_out("oor_setup_pending", K_PEND, 'b010010, 1);
      wait_neg(1);
      clear_inputs();
      wait_neg(2);
      bus.curr_floor = 3'd7;
      bus.arrived = 1'b1;
      expect_out("oor_pending", K_PEND, 'b010010, 1);
      expect_out("oor_pending2", K_PEND, 'b010010, 2);
      expect_out("oor_dir", K_DIR, int'(DIR_DOWN), 2);
      expect_out("oor_tfloor4", K_TF, 4, 2);
      wait_neg(1);
      bus.arrived = 1'b0;
      wait_neg(2);

      // Asynchronous reset mid-sweep, sampled before any clock edge
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_rst_pending", int'(bus.pending), 0);
      check_eq("async_rst_dir", int'(bus.dir), int'(DIR_IDLE));
      check_eq("async_rst_tvalid", int'(bus.target_valid), 0);
      wait_neg(1);
      reset = 1'b1;
      bus.curr_floor = 3'd0;
      expect_out("post_rst_pending", K_PEND, 0, 1);
      expect_out("post_rst_dir", K_DIR, int'(DIR_IDLE), 2);
      wait_neg(3);

      check_eq("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Parametrised successor to the six-floor button latch.
- Latches cab, hall-up and hall-down requests for NUM_FLOORS floors and clears them on arrival with direction awareness.
- Runs a SCAN direction state machine and presents a registered next-target floor to the car motion controller.
- Sits between the switch/button debounce logic and the car FSM.

Parameters:
- NUM_FLOORS, 6: number of floors, legal range 2..16.
- FLOOR_W, $clog2(NUM_FLOORS): width of floor indices. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it clears all state immediately; deassertion is synchronous to clk upstream.
- req_cab  input  NUM_FLOORS  cab button per floor; level-sensitive, sampled every cycle.
- req_up  input  NUM_FLOORS  hall up button per floor.
- req_down  input  NUM_FLOORS  hall down button per floor.
- curr_floor  input  FLOOR_W  floor the car is at or passing.
- arrived  input  1  single-cycle pulse: car stopped at curr_floor and doors opened.
- pending  output  NUM_FLOORS  OR of latched cab/up/down requests per floor; drives floor LEDs.
- target_floor  output  FLOOR_W  next floor the car must serve.
- target_valid  output  1  target_floor is meaningful.
- dir  output  2  current sweep direction, type dir_t.

Behaviour:
- Reset (asynchronous, reset==0): all latches=0, pending=0, dir=DIR_IDLE, target_floor=0, target_valid=0.
- Request masking: req_up[NUM_FLOORS-1] and req_down[0] are ignored; those latch bits are held at 0.
- Latch update, evaluated per floor i on each clk edge:
  - If arrived and i==curr_floor: cab latch cleared.
  - Up latch cleared if dir!=DIR_DOWN; down latch cleared if dir!=DIR_UP. The other hall latch holds.
  - Otherwise a request bit that is 1 sets the latch; else the latch holds.
  - Clear beats set in the same cycle at the same floor and type.
- arrived with curr_floor>=NUM_FLOORS: ignored; no clears.
- Definitions: above = any latch at a floor > curr_floor; below = any latch at a floor < curr_floor.
- Direction FSM (states DIR_IDLE, DIR_UP, DIR_DOWN), registered, evaluated every cycle:
  - IDLE: above -> UP; else below -> DOWN; else stay. If both above and below, UP wins.
  - UP: above -> stay; else below -> DOWN; else IDLE.
  - DOWN: below -> stay; else above -> UP; else IDLE.
  - A request at curr_floor alone never changes dir.
- Target selection, registered, computed from the current latches and dir_next:
  - UP: lowest floor > curr_floor with cab or up latch set. If none, highest floor with any latch set.
  - DOWN: highest floor < curr_floor with cab or down latch set. If none, lowest floor with any latch set.
  - IDLE: curr_floor if its own latch is set, else target_valid=0.
  - target_valid=1 whenever any latch is set; target_floor holds its last value when target_valid=0.
- Latency:
  - Request at edge t -> pending visible after edge t.
  - dir and target reflect it after edge t+1.
  - arrived at edge t -> cleared bits drop after edge t; target updates after edge t+1.
- Reset mid-sweep: dir returns to IDLE at once and all requests are lost.
- No combinational path from any input to any output.

Decomposition:
- Package elevator_pkg holds:
  - typedef enum logic [1:0] dir_t {DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10}.
  - Constant MAX_FLOORS=16.
  - Functions highest_set and lowest_set, each taking a vector and a floor bound.
- Sub-module elevator_request_latch: one instance per request type. Inputs are the request vector, arrived, curr_floor and a clear-enable; output is the latch vector. The top level holds the FSM and target logic.

Test Plan (NUM_FLOORS=6):
- Reset: hold reset=0 mid-run with latches set -> pending=0, dir=IDLE, target_valid=0 immediately, before any clk edge.
- Simple up: curr_floor=0, pulse req_cab[4] -> pending=6'b010000 after 1 edge; dir=UP, target_floor=4, target_valid=1 after 2 edges.
- SCAN ordering:
  - Setup: curr_floor=2, dir=UP; set req_cab[5], req_up[3], req_down[1].
  - Expect target=3; after arrived at 3, target=5.
  - After arrived at 5: dir=DOWN, target=1.
- Direction-aware clear: curr_floor=3, dir=UP, latches up[3] and down[3] set, arrived -> up[3] cleared, down[3] still set, pending[3]=1.
- Masking/simultaneous: assert req_up[5], req_down[0] -> no latch set. Assert req_cab[2] while arrived at curr_floor=2 -> pending[2]=0.
- Out-of-range: curr_floor=7 with arrived and latches set -> no latch changes.
